// File: rtl/ysyx_bpu_if.sv
// Fetch/execute <-> branch predictor bundle.
// master: the pipeline side (drives fetch PC and resolved-branch feedback).
// slave : the predictor (returns prediction, redirect and mispredict count).
interface ysyx_bpu_if;
   logic        fetch_pc_dummy_unused;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [2:0]  upd_type;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] mispred_cnt;

   modport master (
      output fetch_pc,
      output upd_valid,
      output upd_pc,
      output upd_type,
      output upd_taken,
      output upd_target,
      output upd_pred_taken,
      output upd_pred_pc,
      input  pred_taken,
      input  pred_pc,
      input  redirect_valid,
      input  redirect_pc,
      input  mispred_cnt
   );

   modport slave (
      input  fetch_pc,
      input  upd_valid,
      input  upd_pc,
      input  upd_type,
      input  upd_taken,
      input  upd_target,
      input  upd_pred_taken,
      input  upd_pred_pc,
      output pred_taken,
      output pred_pc,
      output redirect_valid,
      output redirect_pc,
      output mispred_cnt
   );
endinterface

// File: rtl/ysyx_bpu.sv
// ysyx_bpu: direct-mapped branch predictor for the NPC fetch stage.
// Each entry holds valid/tag/target plus a 2-bit saturating counter.
// Prediction is combinational from the registered table; resolved branches
// from execute update the table one edge later and raise a one-cycle
// registered redirect whenever the PC carried down the pipe was wrong.
module ysyx_bpu #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 8
) (
   input  logic      clk,
   input  logic      rst,
   ysyx_bpu_if.slave bus
);

   localparam int DEPTH = 1 << IDX_W;

   // Saturating increment of a 2-bit confidence counter.
   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      logic [1:0] r;
      if (c == 2'b11) begin
         r = 2'b11;
      end else begin
         r = c + 2'b01;
      end
      return r;
   endfunction

   // Saturating decrement of a 2-bit confidence counter.
   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      logic [1:0] r;
      if (c == 2'b00) begin
         r = 2'b00;
      end else begin
         r = c - 2'b01;
      end
      return r;
   endfunction

   // Table index: word-aligned PC bits just above the byte offset.
   function automatic logic [IDX_W-1:0] pc_index(input logic [31:0] pc);
      return pc[IDX_W+1:2];
   endfunction

   // Tag: the PC bits directly above the index.
   function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
      return pc[IDX_W+TAG_W+1:IDX_W+2];
   endfunction

   // Prediction table state.
   logic              valid_r  [DEPTH];
   logic [TAG_W-1:0]  tag_r    [DEPTH];
   logic [31:0]       target_r [DEPTH];
   logic [1:0]        ctr_r    [DEPTH];

   // Registered outputs.
   logic              redirect_valid_r;
   logic [31:0]       redirect_pc_r;
   logic [31:0]       mispred_cnt_r;

   // Predict-side signals.
   logic [IDX_W-1:0]  fetch_idx_s;
   logic              fetch_hit_s;
   logic              pred_taken_s;
   logic [31:0]       pred_pc_s;

   // Update-side signals.
   logic [IDX_W-1:0]  upd_idx_s;
   logic [TAG_W-1:0]  upd_tag_s;
   logic              upd_is_br_s;
   logic              upd_active_s;
   logic              upd_hit_s;
   logic [31:0]       correct_pc_s;
   logic              mispredict_s;

   // Entry write-back values for the indexed slot.
   logic              wr_en_s;
   logic              wr_valid_s;
   logic [TAG_W-1:0]  wr_tag_s;
   logic [31:0]       wr_target_s;
   logic [1:0]        wr_ctr_s;

   // Next-state values for the redirect/statistics registers.
   logic              redirect_valid_nxt_s;
   logic [31:0]       redirect_pc_nxt_s;
   logic [31:0]       mispred_cnt_nxt_s;

   // The direction bit and the PC bits outside index/tag are not needed by
   // this predictor; fold them into one sink so they stay visibly consumed.
   logic              unused_bits_s;
   assign unused_bits_s = ^{bus.upd_pred_taken, bus.fetch_pc, bus.upd_pc};

   // Lookup of the fetch PC against the current (pre-update) table.
   always_comb begin
      fetch_idx_s  = pc_index(bus.fetch_pc);
      fetch_hit_s  = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == pc_tag(bus.fetch_pc));
      pred_taken_s = fetch_hit_s && ctr_r[fetch_idx_s][1];
      if (pred_taken_s) begin
         pred_pc_s = target_r[fetch_idx_s];
      end else begin
         pred_pc_s = bus.fetch_pc + 32'd4;
      end
   end

   assign bus.pred_taken = pred_taken_s;
   assign bus.pred_pc    = pred_pc_s;

   // Decode the resolved branch and decide whether the carried PC was wrong.
   always_comb begin
      upd_idx_s = pc_index(bus.upd_pc);
      upd_tag_s = pc_tag(bus.upd_pc);
      case (bus.upd_type)
         3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111: upd_is_br_s = 1'b1;
         default:                                        upd_is_br_s = 1'b0;
      endcase
      upd_active_s = bus.upd_valid && upd_is_br_s;
      upd_hit_s    = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
      if (bus.upd_taken) begin
         correct_pc_s = bus.upd_target;
      end else begin
         correct_pc_s = bus.upd_pc + 32'd4;
      end
      mispredict_s = (bus.upd_pred_pc != correct_pc_s);
   end

   // Compute the new contents of the indexed entry (train on hit, allocate on taken miss).
   always_comb begin
      wr_en_s     = 1'b0;
      wr_valid_s  = valid_r[upd_idx_s];
      wr_tag_s    = tag_r[upd_idx_s];
      wr_target_s = target_r[upd_idx_s];
      wr_ctr_s    = ctr_r[upd_idx_s];
      if (upd_active_s) begin
         if (upd_hit_s) begin
            wr_en_s = 1'b1;
            if (bus.upd_taken) begin
               wr_ctr_s    = ctr_inc(ctr_r[upd_idx_s]);
               wr_target_s = bus.upd_target;
            end else begin
               wr_ctr_s    = ctr_dec(ctr_r[upd_idx_s]);
            end
         end else if (bus.upd_taken) begin
            wr_en_s     = 1'b1;
            wr_valid_s  = 1'b1;
            wr_tag_s    = upd_tag_s;
            wr_target_s = bus.upd_target;
            wr_ctr_s    = 2'b10;
         end else begin
            wr_en_s = 1'b0;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Table storage: cleared by reset, one entry written per active update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= 32'h0000_0000;
            ctr_r[i]    <= 2'b01;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_s && (upd_idx_s == i[IDX_W-1:0])) begin
               valid_r[i]  <= wr_valid_s;
               tag_r[i]    <= wr_tag_s;
               target_r[i] <= wr_target_s;
               ctr_r[i]    <= wr_ctr_s;
            end
         end
      end
   end

   // Next redirect pulse, held redirect PC and saturating mispredict count.
   always_comb begin
      redirect_valid_nxt_s = upd_active_s && mispredict_s;
      if (redirect_valid_nxt_s) begin
         redirect_pc_nxt_s = correct_pc_s;
      end else begin
         redirect_pc_nxt_s = redirect_pc_r;
      end
      if (redirect_valid_nxt_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
         mispred_cnt_nxt_s = mispred_cnt_r + 32'd1;
      end else begin
         mispred_cnt_nxt_s = mispred_cnt_r;
      end
   end

   // Redirect and statistics registers; reset drops any pending redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'h0000_0000;
         mispred_cnt_r    <= 32'h0000_0000;
      end else begin
         redirect_valid_r <= redirect_valid_nxt_s;
         redirect_pc_r    <= redirect_pc_nxt_s;
         mispred_cnt_r    <= mispred_cnt_nxt_s;
      end
   end

   assign bus.redirect_valid = redirect_valid_r;
   assign bus.redirect_pc    = redirect_pc_r;
   assign bus.mispred_cnt    = mispred_cnt_r;

endmodule

// File: tb/tb_ysyx_bpu.sv
// Self-checking bench for ysyx_bpu: directed test-plan steps followed by
// randomized updates, all checked against a behavioural table model.
module tb_ysyx_bpu;

   localparam int IDX_W = 4;
   localparam int TAG_W = 8;
   localparam int DEPTH = 1 << IDX_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ysyx_bpu_if bus ();

   ysyx_bpu #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state.
   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_ctr   [DEPTH];
   logic        m_rv;
   logic [31:0] m_rpc;
   logic [31:0] m_cnt;

   function automatic int unsigned m_idx(input logic [31:0] pc);
      return (pc / 4) % DEPTH;
   endfunction

   function automatic int unsigned m_tg(input logic [31:0] pc);
      return (pc / (4 * DEPTH)) % (1 << TAG_W);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
   endfunction

   function automatic logic m_pred_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
      if (m_pred_taken(pc)) return m_tgt[m_idx(pc)];
      return pc + 32'd4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'h0;
         m_ctr[i]   = 1;
      end
      m_rv  = 1'b0;
      m_rpc = 32'h0;
      m_cnt = 32'h0;
   endtask

   task automatic model_update(input logic uv, input logic [2:0] ut, input logic [31:0] upc,
                               input logic tk, input logic [31:0] tgt, input logic [31:0] ppc);
      int unsigned i;
      logic [31:0] correct;
      if (uv && (ut >= 3'd2)) begin
         i = m_idx(upc);
         correct = tk ? tgt : upc + 32'd4;
         if (m_hit(upc)) begin
            if (tk) begin
               m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = tgt;
            end else begin
               m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tg(upc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
         end
         if (ppc != correct) begin
            m_rv  = 1'b1;
            m_rpc = correct;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         end else begin
            m_rv = 1'b0;
         end
      end else begin
         m_rv = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: drive, check prediction before the edge, check redirect after it.
   // Entered and left at 1 time unit after a rising edge.
   task automatic step(input logic [31:0] fpc, input logic uv, input logic [2:0] ut,
                       input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] ppc);
      bus.fetch_pc       = fpc;
      bus.upd_valid      = uv;
      bus.upd_type       = ut;
      bus.upd_pc         = upc;
      bus.upd_taken      = tk;
      bus.upd_target     = tgt;
      bus.upd_pred_pc    = ppc;
      bus.upd_pred_taken = (ppc != upc + 32'd4);
      #2;
      chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, m_pred_taken(fpc)});
      chk("pred_pc", bus.pred_pc, m_pred_pc(fpc));
      model_update(uv, ut, upc, tk, tgt, ppc);
      @(posedge clk);
      #1;
      chk("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_rv});
      chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("mispred_cnt", bus.mispred_cnt, m_cnt);
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] base;
      case ($urandom_range(0, 2))
         0:       base = 32'h8000_0000;
         1:       base = 32'h8000_0400;
         default: base = 32'h8000_2000;
      endcase
      return base + ($urandom_range(0, 31) * 4);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      logic [31:0] upc, ppc, tgt;
      logic [2:0]  ut;
      logic        tk, uv;

      model_reset();
      bus.fetch_pc = 32'h8000_0000; bus.upd_valid = 1'b0; bus.upd_type = 3'b000;
      bus.upd_pc = 32'h0; bus.upd_taken = 1'b0; bus.upd_target = 32'h0;
      bus.upd_pred_taken = 1'b0; bus.upd_pred_pc = 32'h0;
      @(posedge clk); @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      step(32'h8000_0000, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("rst_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
      chk("rst_pred_pc", bus.pred_pc, 32'h8000_0004);
      chk("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      chk("rst_mispred_cnt", bus.mispred_cnt, 32'd0);

      // Taken miss allocates and redirects.
      step(32'h8000_0010, 1'b1, 3'b010, 32'h8000_0010, 1'b1, 32'h8000_0040, 32'h8000_0014);
      chk("alloc_rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("alloc_rpc", bus.redirect_pc, 32'h8000_0040);
      chk("alloc_cnt", bus.mispred_cnt, 32'd1);
      step(32'h8000_0010, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("alloc_pred_taken", {31'd0, bus.pred_taken}, 32'd1);
      chk("alloc_pred_pc", bus.pred_pc, 32'h8000_0040);
      chk("pulse_ends", {31'd0, bus.redirect_valid}, 32'd0);

      // Two not-taken resolutions: ctr 2->1 (redirect), 1->0 (no redirect).
      step(32'h8000_0010, 1'b1, 3'b011, 32'h8000_0010, 1'b0, 32'h8000_0040, 32'h8000_0040);
      chk("nt1_rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("nt1_rpc", bus.redirect_pc, 32'h8000_0014);
      step(32'h8000_0010, 1'b1, 3'b011, 32'h8000_0010, 1'b0, 32'h8000_0040, 32'h8000_0014);
      chk("nt2_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("nt2_rpc_held", bus.redirect_pc, 32'h8000_0014);
      chk("nt2_pred_pc", bus.pred_pc, 32'h8000_0014);
      chk("nt2_cnt", bus.mispred_cnt, 32'd2);

      // Taken with a wrong target carried down the pipe.
      step(32'h8000_0010, 1'b1, 3'b100, 32'h8000_0010, 1'b1, 32'h8000_0080, 32'h8000_0040);
      chk("tgt_rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("tgt_rpc", bus.redirect_pc, 32'h8000_0080);
      step(32'h8000_0010, 1'b1, 3'b100, 32'h8000_0010, 1'b1, 32'h8000_0080, 32'h8000_0080);
      chk("tgt_stored", bus.pred_pc, 32'h8000_0080);

      // Alias eviction by a different tag at the same index.
      step(32'h8000_0410, 1'b1, 3'b101, 32'h8000_0410, 1'b1, 32'h8000_0500, 32'h8000_0414);
      step(32'h8000_0010, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("alias_evicted", bus.pred_pc, 32'h8000_0014);
      step(32'h8000_0410, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("alias_new", bus.pred_pc, 32'h8000_0500);

      // Non-branch type is ignored.
      step(32'h8000_0410, 1'b1, 3'b000, 32'h8000_0410, 1'b1, 32'h1234_5678, 32'h0);
      chk("nonbr_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("nonbr_table", bus.pred_pc, 32'h8000_0500);

      // Reset right after a mispredict drops the pulse immediately.
      step(32'h8000_0020, 1'b1, 3'b110, 32'h8000_0020, 1'b1, 32'h8000_0100, 32'h8000_0024);
      chk("pre_rst_rv", {31'd0, bus.redirect_valid}, 32'd1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("async_rst_rpc", bus.redirect_pc, 32'd0);
      chk("async_rst_cnt", bus.mispred_cnt, 32'd0);
      bus.fetch_pc = 32'h8000_0410;
      #1;
      chk("rst_inval_410", bus.pred_pc, 32'h8000_0414);
      bus.fetch_pc = 32'h8000_0020;
      #1;
      chk("rst_inval_020", bus.pred_pc, 32'h8000_0024);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         upc = rand_pc();
         uv  = ($urandom_range(0, 7) != 0);
         ut  = 3'($urandom_range(0, 7));
         tk  = 1'($urandom_range(0, 1));
         tgt = ($urandom_range(0, 3) == 0) ? rand_pc() : m_tgt[m_idx(upc)];
         if (tgt == 32'h0) tgt = rand_pc();
         ppc = ($urandom_range(0, 3) != 0) ? m_pred_pc(upc) : rand_pc();
         step(rand_pc(), uv, ut, upc, tk, tgt, ppc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ysyx_bpu.md
# ysyx_bpu

Fetch-side branch prediction unit for the NPC core, built around the condition codes evaluated in execute. Each cycle it predicts next-PC for the fetch address from a direct-mapped table of 2-bit saturating counters with stored targets. The branch comparator's resolved outcome (BrE plus computed target) comes back from execute to update the table. The block then raises a registered one-cycle redirect when the prediction used by that branch was wrong.

## Interface
- IDX_W, 4: index bits; table depth 2^IDX_W entries.
- TAG_W, 8: stored tag bits; TAG_W <= 30-IDX_W.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_pc  in  32  PC being fetched this cycle.
- pred_taken  out  1  combinational: predicted taken for fetch_pc.
- pred_pc  out  32  combinational: predicted next PC.
- upd_valid  in  1  a resolved control instruction is presented this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_type  in  3  branch type, same code as comparator: 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; others = not a conditional branch.
- upd_taken  in  1  resolved outcome (comparator BrE).
- upd_target  in  32  resolved taken target.
- upd_pred_taken  in  1  pred_taken carried down the pipe with this instruction.
- upd_pred_pc  in  32  pred_pc carried down the pipe with this instruction.
- redirect_valid  out  1  registered: fetch must restart at redirect_pc.
- redirect_pc  out  32  registered: correct next PC.
- mispred_cnt  out  32  registered: saturating count of mispredictions.

## Operation
- Entry fields: valid, tag[TAG_W-1:0], target[31:0], ctr[1:0]. index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Reset: all valid=0, ctr=2'b01, target=0, tag=0; redirect_valid=0, redirect_pc=0, mispred_cnt=0.
- Predict: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_pc = pred_taken ? target : fetch_pc+4, mod 2^32.
- Update is active when upd_valid=1 and upd_type in 010..111. Otherwise the table, the counter and redirect are all untouched, and redirect_valid=0 next cycle.
- Hit update: if upd_taken, ctr = min(ctr+1, 3) and target = upd_target. If not taken, ctr = max(ctr-1, 0) and target is kept.
- Miss update with taken: allocate or overwrite the entry at index (valid=1, new tag, target=upd_target, ctr=2'b10).
- Miss update with not taken: no table change.
- Correct PC: correct = upd_taken ? upd_target : upd_pc+4.
- Mispredict: mispredict = (upd_pred_pc != correct). This also covers a direction match with a wrong target.
- On an active update with mispredict: redirect_valid=1 and redirect_pc=correct in the next cycle; mispred_cnt increments, holding at 32'hFFFFFFFF.
- If there is no mispredict, redirect_valid=0 next cycle and redirect_pc holds its previous value.

## Timing
- Prediction has zero latency; it is combinational from fetch_pc and the registered table.
- Update and redirect latency is 1 cycle. Table write and redirect_valid both take effect after the rising edge where upd_valid=1.
- redirect_valid is a single-cycle pulse per mispredicted update. Back-to-back mispredicts give consecutive pulses.
- Same-index predict and update in the same cycle: the prediction uses pre-update state. There is no bypass.
- Reset asserted mid-operation clears state immediately. Outputs go to reset values without waiting for a clock; a pending redirect is dropped.

## Test plan
- Reset then fetch_pc=0x80000000 -> pred_taken=0, pred_pc=0x80000004; redirect_valid=0, mispred_cnt=0.
- Update pc=0x80000010, type=010, taken=1, target=0x80000040, pred_pc=0x80000014 -> next cycle redirect_valid=1, redirect_pc=0x80000040, mispred_cnt=1. Then fetch_pc=0x80000010 -> pred_taken=1, pred_pc=0x80000040.
- Same branch resolved not-taken twice, with pred_pc matching the prediction each time:
  - First update (ctr 2->1): predicted 0x80000040, correct 0x80000014 -> redirect to 0x80000014.
  - Second update (ctr 1->0): predicted 0x80000014 -> no redirect.
  - Prediction is now 0x80000014; mispred_cnt=2.
- Hit with right direction, wrong target: entry target 0x80000040, upd_target=0x80000080, taken=1 -> redirect_pc=0x80000080; stored target becomes 0x80000080.
- Alias: pc 0x80000010 and pc 0x80000410 share an index with IDX_W=4 but differ in tag. A taken update on 0x80000410 evicts the entry; fetch of 0x80000010 then predicts 0x80000014.
- upd_type=000 with upd_valid=1 and mismatching pred -> no table change, no redirect. Assert rst for one cycle right after a mispredicting update -> redirect_valid=0 immediately and all entries invalid.
